// File: rtl/run_ctl_pkg.sv
// Shared definitions for the RUN flip-flop control stage: state encoding,
// halt-cause codes and default sizing.
package run_ctl_pkg;

  localparam int DEF_CNT_W   = 8;
  localparam int DEF_PULSE_W = 2;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_SETTING  = 3'd1;
  localparam logic [2:0] S_RUNNING  = 3'd2;
  localparam logic [2:0] S_STEPPING = 3'd3;
  localparam logic [2:0] S_CLEARING = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE     = S_IDLE,
    ST_SETTING  = S_SETTING,
    ST_RUNNING  = S_RUNNING,
    ST_STEPPING = S_STEPPING,
    ST_CLEARING = S_CLEARING
  } run_state_e;

  // Reason the last run ended (reported when RUN_HALT_CAUSE_EN is defined)
  localparam logic [1:0] CAUSE_NONE  = 2'd0;
  localparam logic [1:0] CAUSE_STOP  = 2'd1;
  localparam logic [1:0] CAUSE_STEPS = 2'd2;
  localparam logic [1:0] CAUSE_HALT  = 2'd3;

endpackage

// File: rtl/run_step_ctl_if.sv
// Spy-bus / RUN flip-flop signal bundle for run_step_ctl.
// HALT_CAUSE exists only when RUN_HALT_CAUSE_EN is defined.
interface run_step_ctl_if import run_ctl_pkg::*; #(
  parameter int CNT_W = DEF_CNT_W
);
  logic             START;
  logic             STOP;
  logic             STEP;
  logic [CNT_W-1:0] STEP_COUNT;
  logic             UINST_ADV;
  logic             HALT_REQ;
  logic             RUN_Q;
  logic             RUN_S_N;
  logic             RUN_R_N;
  logic [CNT_W-1:0] STEPS_LEFT;
  logic             BUSY;
  logic             DONE;
`ifdef RUN_HALT_CAUSE_EN
  logic [1:0]       HALT_CAUSE;
`endif

  modport master (
`ifdef RUN_HALT_CAUSE_EN
    input  HALT_CAUSE,
`endif
    output START, STOP, STEP, STEP_COUNT, UINST_ADV, HALT_REQ, RUN_Q,
    input  RUN_S_N, RUN_R_N, STEPS_LEFT, BUSY, DONE
  );

  modport slave (
`ifdef RUN_HALT_CAUSE_EN
    output HALT_CAUSE,
`endif
    input  START, STOP, STEP, STEP_COUNT, UINST_ADV, HALT_REQ, RUN_Q,
    output RUN_S_N, RUN_R_N, STEPS_LEFT, BUSY, DONE
  );
endinterface

// File: rtl/run_pulse_gen.sv
// Active-low pulse generator: a fire strobe produces a registered low pulse
// of exactly PULSE_W cycles starting the cycle after the strobe.
// 'last' marks the final low cycle so the caller can leave on that edge.
module run_pulse_gen import run_ctl_pkg::*; #(
  parameter int PULSE_W = DEF_PULSE_W
) (
  input  logic clk,
  input  logic rst,
  input  logic fire,
  output logic pulse_n,
  output logic last
);
  logic [2:0] cnt_q, cnt_d;
  logic       pulse_n_q, pulse_n_d;

  // Reload on fire, otherwise count down to zero; output is low while nonzero
  always_comb begin
    cnt_d = cnt_q;
    if (fire)                cnt_d = 3'(PULSE_W);
    else if (cnt_q != 3'd0)  cnt_d = cnt_q - 3'd1;
    pulse_n_d = (cnt_d == 3'd0);
  end

  // Counter and output register; reset releases the pulse at once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= 3'd0;
      pulse_n_q <= 1'b1;
    end else begin
      cnt_q     <= cnt_d;
      pulse_n_q <= pulse_n_d;
    end
  end

  assign pulse_n = pulse_n_q;
  assign last    = (cnt_q == 3'd1);
endmodule

// File: rtl/run_step_ctl.sv
// RUN flip-flop control: turns start/stop/step strobes and halt requests
// into clean set/clear pulses, counts step bursts, reports busy/done.
// Optional macro RUN_HALT_CAUSE_EN adds the HALT_CAUSE status output.
module run_step_ctl import run_ctl_pkg::*; #(
  parameter int CNT_W   = DEF_CNT_W,
  parameter int PULSE_W = DEF_PULSE_W
) (
  input logic           CLK,
  input logic           RESET,
  run_step_ctl_if.slave bus
);
  run_state_e       state_q, state_d;
  logic             step_mode_q, step_mode_d;  // 1: burst of STEPS_LEFT
  logic             stop_pend_q, stop_pend_d;  // STOP seen while setting
  logic             fired_q, fired_d;          // pulse already launched here
  logic [CNT_W-1:0] steps_q, steps_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             set_fire, clr_fire;
  logic             set_n, set_last, clr_n, clr_last;

  run_pulse_gen #(.PULSE_W(PULSE_W)) u_set (
    .clk(CLK), .rst(RESET), .fire(set_fire), .pulse_n(set_n), .last(set_last));
  run_pulse_gen #(.PULSE_W(PULSE_W)) u_clr (
    .clk(CLK), .rst(RESET), .fire(clr_fire), .pulse_n(clr_n), .last(clr_last));

  // Next-state, step counting and pulse launch; HALT > STOP > STEP > START
  always_comb begin
    state_d     = state_q;
    step_mode_d = step_mode_q;
    stop_pend_d = stop_pend_q;
    fired_d     = fired_q;
    steps_d     = steps_q;
    done_d      = 1'b0;
    set_fire    = 1'b0;
    clr_fire    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if ((bus.HALT_REQ && (bus.START || bus.STEP)) || bus.STOP) begin
          done_d = 1'b1;
        end else if (bus.STEP) begin
          if (bus.STEP_COUNT == '0) begin
            done_d = 1'b1;
          end else begin
            steps_d     = bus.STEP_COUNT;
            step_mode_d = 1'b1;
            state_d     = ST_SETTING;
          end
        end else if (bus.START) begin
          step_mode_d = 1'b0;
          state_d     = ST_SETTING;
        end
      end
      ST_SETTING: begin
        set_fire = !fired_q;
        if (bus.STOP) stop_pend_d = 1'b1;
        // Leave on the last low cycle; a pending stop or halt turns straight
        // into a clear, otherwise settle into the requested mode.
        if (fired_q && set_last) begin
          if (bus.HALT_REQ || bus.STOP || stop_pend_q) state_d = ST_CLEARING;
          else if (step_mode_q)                        state_d = ST_STEPPING;
          else                                         state_d = ST_RUNNING;
        end
      end
      ST_RUNNING: begin
        if (bus.HALT_REQ || bus.STOP) state_d = ST_CLEARING;
      end
      ST_STEPPING: begin
        if (bus.HALT_REQ || bus.STOP) begin
          state_d = ST_CLEARING;
        end else if (bus.UINST_ADV && steps_q != '0) begin
          steps_d = steps_q - CNT_W'(1);
          if (steps_q == CNT_W'(1)) state_d = ST_CLEARING;
        end
      end
      ST_CLEARING: begin
        clr_fire = !fired_q;
        // Done once the clear pulse has run its full width and RUN has dropped
        if (fired_q && (clr_last || clr_n) && !bus.RUN_Q) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (state_d != state_q) begin
      fired_d     = 1'b0;
      stop_pend_d = 1'b0;
    end else if (set_fire || clr_fire) begin
      fired_d = 1'b1;
    end
    busy_d = (state_d != ST_IDLE);
  end

  // State and status registers
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q     <= ST_IDLE;
      step_mode_q <= 1'b0;
      stop_pend_q <= 1'b0;
      fired_q     <= 1'b0;
      steps_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      step_mode_q <= step_mode_d;
      stop_pend_q <= stop_pend_d;
      fired_q     <= fired_d;
      steps_q     <= steps_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign bus.RUN_S_N    = set_n;
  assign bus.RUN_R_N    = clr_n;
  assign bus.STEPS_LEFT = steps_q;
  assign bus.BUSY       = busy_q;
  assign bus.DONE       = done_q;

`ifdef RUN_HALT_CAUSE_EN
  logic [1:0] cause_q, cause_d;

  // Latch why the run is ending on entry to clearing; a new run clears it
  always_comb begin
    cause_d = cause_q;
    if (state_d == ST_SETTING && state_q != ST_SETTING) begin
      cause_d = CAUSE_NONE;
    end else if (state_d == ST_CLEARING && state_q != ST_CLEARING) begin
      if (bus.HALT_REQ)                  cause_d = CAUSE_HALT;
      else if (bus.STOP || stop_pend_q)  cause_d = CAUSE_STOP;
      else                               cause_d = CAUSE_STEPS;
    end
  end

  // Halt-cause register
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) cause_q <= CAUSE_NONE;
    else       cause_q <= cause_d;
  end

  assign bus.HALT_CAUSE = cause_q;
`endif
endmodule

// File: tb/tb_run_step_ctl.sv
// Self-checking bench for run_step_ctl: cycle-level reference model, a
// per-cycle compare process, directed literal checks and random stimulus.
module tb_run_step_ctl;
  localparam int CNT_W = 8;
  localparam int PW    = 2;

  logic CLK = 1'b0;
  logic RESET;
  int   checks = 0;
  int   errors = 0;

  always #5 CLK = ~CLK;

  run_step_ctl_if #(.CNT_W(CNT_W)) bus ();
  run_step_ctl #(.CNT_W(CNT_W), .PULSE_W(PW)) dut (.CLK(CLK), .RESET(RESET), .bus(bus));

  // RUN flip-flop (set dominant) plus an optional hold that keeps Q high
  logic run_ff, run_hold;
  always @(posedge CLK or posedge RESET)
    if (RESET)             run_ff <= 1'b0;
    else if (!bus.RUN_S_N) run_ff <= 1'b1;
    else if (!bus.RUN_R_N) run_ff <= 1'b0;
  assign bus.RUN_Q = run_ff | run_hold;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: phase plus cycles-in-phase; pulses are low for
  // ages 1..PW of the setting/clearing phases.
  localparam int M_IDLE = 0, M_SET = 1, M_RUN = 2, M_STEP = 3, M_CLR = 4;
  int m_ph = M_IDLE, m_age = 0, m_left = 0, m_cause = 0;
  bit m_stepmode = 0, m_pend = 0, m_done = 0;

  always @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      m_ph = M_IDLE; m_age = 0; m_left = 0; m_cause = 0;
      m_stepmode = 0; m_pend = 0; m_done = 0;
    end else begin
      int  nx;
      bit  halt, stop, step, start, adv;
      int  cnt;
      halt = bus.HALT_REQ; stop = bus.STOP; step = bus.STEP;
      start = bus.START; adv = bus.UINST_ADV; cnt = int'(bus.STEP_COUNT);
      nx = m_ph; m_done = 0;
      case (m_ph)
        M_IDLE:
          if ((halt && (start || step)) || stop || (step && cnt == 0)) m_done = 1;
          else if (step) begin m_left = cnt; m_stepmode = 1; nx = M_SET; end
          else if (start) begin m_stepmode = 0; nx = M_SET; end
        M_SET: begin
          if (stop) m_pend = 1;
          if (m_age == PW) nx = (halt || m_pend) ? M_CLR : (m_stepmode ? M_STEP : M_RUN);
        end
        M_RUN: if (halt || stop) nx = M_CLR;
        M_STEP:
          if (halt || stop) nx = M_CLR;
          else if (adv && m_left > 0) begin
            m_left--;
            if (m_left == 0) nx = M_CLR;
          end
        default:
          if (m_age >= PW && !bus.RUN_Q) begin nx = M_IDLE; m_done = 1; end
      endcase
      if (nx == M_CLR && m_ph != M_CLR) m_cause = halt ? 3 : ((stop || m_pend) ? 1 : 2);
      if (nx == M_SET && m_ph != M_SET) m_cause = 0;
      if (nx != m_ph) begin m_age = 0; m_pend = 0; end
      else if (m_age < 1000) m_age++;
      m_ph = nx;
    end
  end

  // Compare DUT against the model every cycle, away from the active edge
  int n_slow = 0, n_rlow = 0, n_done = 0;
  always @(negedge CLK) begin
    chk("run_s_n", bus.RUN_S_N, !(m_ph == M_SET && m_age >= 1 && m_age <= PW));
    chk("run_r_n", bus.RUN_R_N, !(m_ph == M_CLR && m_age >= 1 && m_age <= PW));
    chk("steps_left", bus.STEPS_LEFT, m_left);
    chk("busy", bus.BUSY, m_ph != M_IDLE);
    chk("done", bus.DONE, m_done);
`ifdef RUN_HALT_CAUSE_EN
    chk("halt_cause", bus.HALT_CAUSE, m_cause);
`endif
    checks++;
    assert (bus.RUN_S_N || bus.RUN_R_N)
    else begin
      errors++;
      $display("FAIL set_clr_overlap both pulse outputs low t=%0t", $time);
    end
    if (!bus.RUN_S_N) n_slow++;
    if (!bus.RUN_R_N) n_rlow++;
    if (bus.DONE)     n_done++;
  end

  task automatic clr_cnt();
    n_slow = 0; n_rlow = 0; n_done = 0;
  endtask

  task automatic drive(input bit st, input bit sp, input bit sx, input int cnt, input bit adv);
    bus.START = st; bus.STOP = sp; bus.STEP = sx;
    bus.STEP_COUNT = CNT_W'(cnt); bus.UINST_ADV = adv;
    @(posedge CLK); #1;
    bus.START = 0; bus.STOP = 0; bus.STEP = 0; bus.UINST_ADV = 0;
  endtask

  task automatic idle_cyc(input int n);
    repeat (n) begin @(posedge CLK); #1; end
  endtask

  initial begin
    RESET = 1'b1; run_hold = 1'b0;
    bus.START = 0; bus.STOP = 0; bus.STEP = 0; bus.STEP_COUNT = '0;
    bus.UINST_ADV = 0; bus.HALT_REQ = 0;
    idle_cyc(2);
    chk("rst_run_s_n", bus.RUN_S_N, 1); chk("rst_run_r_n", bus.RUN_R_N, 1);
    chk("rst_steps", bus.STEPS_LEFT, 0); chk("rst_busy", bus.BUSY, 0);
    chk("rst_done", bus.DONE, 0);
    RESET = 1'b0;
    idle_cyc(2);

    // Free run then stop
    clr_cnt(); drive(1, 0, 0, 0, 0); idle_cyc(6);
    chk("start_slow_cycles", n_slow, 2); chk("start_busy", bus.BUSY, 1);
    clr_cnt(); drive(0, 1, 0, 0, 0); idle_cyc(8);
    chk("stop_rlow_cycles", n_rlow, 2); chk("stop_done_count", n_done, 1);
    chk("stop_busy", bus.BUSY, 0);

    // Step burst of 3 runs to exhaustion
    clr_cnt(); drive(0, 0, 1, 3, 0); idle_cyc(4);
    chk("step3_loaded", bus.STEPS_LEFT, 3);
    drive(0, 0, 0, 0, 1); chk("step3_left2", bus.STEPS_LEFT, 2);
    idle_cyc(1);
    drive(0, 0, 0, 0, 1); chk("step3_left1", bus.STEPS_LEFT, 1);
    drive(0, 0, 0, 0, 1); chk("step3_left0", bus.STEPS_LEFT, 0);
    chk("step3_busy_clr", bus.BUSY, 1);
    idle_cyc(8);
    chk("step3_done_count", n_done, 1);
`ifdef RUN_HALT_CAUSE_EN
    chk("step3_cause", bus.HALT_CAUSE, 2);
`endif

    // Step burst of 5 aborted by halt after 2 advances
    drive(0, 0, 1, 5, 0); idle_cyc(4);
    drive(0, 0, 0, 0, 1); drive(0, 0, 0, 0, 1);
    clr_cnt(); bus.HALT_REQ = 1; idle_cyc(1);
    chk("halt_steps_held", bus.STEPS_LEFT, 3);
    idle_cyc(8); bus.HALT_REQ = 0;
    chk("halt_done_count", n_done, 1);
`ifdef RUN_HALT_CAUSE_EN
    chk("halt_cause", bus.HALT_CAUSE, 3);
`endif

    // START and STOP together in idle: stop wins
    clr_cnt(); drive(1, 1, 0, 0, 0); idle_cyc(5);
    chk("startstop_done", n_done, 1); chk("startstop_slow", n_slow, 0);

    // Reset in the middle of the set pulse
    drive(1, 0, 0, 0, 0); idle_cyc(1);
    chk("mid_set_low", bus.RUN_S_N, 0);
    RESET = 1'b1; #1;
    chk("rst_async_s_n", bus.RUN_S_N, 1); chk("rst_async_busy", bus.BUSY, 0);
    @(posedge CLK); #1; RESET = 1'b0;
    clr_cnt(); drive(0, 0, 1, 0, 0); idle_cyc(3);
    chk("step0_done", n_done, 1); chk("step0_slow", n_slow, 0);
    chk("step0_busy", bus.BUSY, 0);

    // Random traffic against the model
    for (int i = 0; i < 4000; i++) begin
      bus.START      = ($urandom % 12) == 0;
      bus.STOP       = ($urandom % 25) == 0;
      bus.STEP       = ($urandom % 12) == 0;
      bus.STEP_COUNT = CNT_W'($urandom_range(0, 6));
      bus.UINST_ADV  = ($urandom % 3) == 0;
      if (bus.HALT_REQ) bus.HALT_REQ = ($urandom % 4) != 0;
      else              bus.HALT_REQ = ($urandom % 60) == 0;
      if (($urandom % 4) == 0) run_hold = ($urandom % 3) == 0;
      RESET = ($urandom % 800) == 0;
      @(posedge CLK); #1;
    end
    RESET = 1'b0;
    bus.START = 0; bus.STOP = 0; bus.STEP = 0; bus.UINST_ADV = 0;
    bus.HALT_REQ = 0; run_hold = 0;
    idle_cyc(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/run_step_ctl.md
Name: run_step_ctl

Overview:
- Console-side control stage feeding the active-low set/reset pins of the machine's RUN flip-flop (an ff_rs instance).
- Turns spy-bus strobes (start, stop, step-N) and machine halt requests into clean, width-controlled set/clear pulses.
- Counts microinstruction advances during single-step bursts and drops RUN after exactly N advances.
- Reports busy/done status back to the spy register.

Parameters:
- CNT_W, 8: width of step count and remaining-step counter.
- PULSE_W, 2: cycles RUN_S_N/RUN_R_N are held low per set/clear (1..7).

Ports:
- CLK  in  1  system clock; all state updates on posedge.
- RESET  in  1  asynchronous, active-high reset.
- START  in  1  one-cycle strobe: free-run.
- STOP  in  1  one-cycle strobe: stop.
- STEP  in  1  one-cycle strobe: run STEP_COUNT microinstructions.
- STEP_COUNT  in  CNT_W  step burst length, sampled with STEP.
- UINST_ADV  in  1  one-cycle strobe per executed microinstruction.
- HALT_REQ  in  1  level: machine error/halt condition.
- RUN_Q  in  1  feedback from RUN flip-flop Q.
- RUN_S_N  out  1  active-low set to RUN flip-flop.
- RUN_R_N  out  1  active-low clear to RUN flip-flop.
- STEPS_LEFT  out  CNT_W  remaining steps in current burst.
- BUSY  out  1  high in any state except IDLE.
- DONE  out  1  one-cycle strobe when a stop/step/halt sequence completes.

Behaviour:
- Reset (async): state=IDLE, RUN_S_N=1, RUN_R_N=1, STEPS_LEFT=0, BUSY=0, DONE=0, pulse counter=0.
- RUN_S_N and RUN_R_N are registered outputs and are never low in the same cycle.
- States: IDLE, SETTING, RUNNING, STEPPING, CLEARING.
- IDLE:
  - START goes to SETTING (mode=free).
  - STEP with STEP_COUNT!=0 loads STEPS_LEFT and goes to SETTING (mode=step).
  - STEP with count 0 pulses DONE next cycle and stays in IDLE.
  - STOP in IDLE pulses DONE only.
  - HALT_REQ high blocks START and STEP; DONE is pulsed instead.
- SETTING:
  - Drives RUN_S_N low for exactly PULSE_W cycles, starting the cycle after entry.
  - Then goes to RUNNING or STEPPING according to mode.
- RUNNING: STOP or HALT_REQ goes to CLEARING.
- STEPPING:
  - Each UINST_ADV decrements STEPS_LEFT.
  - The UINST_ADV that takes STEPS_LEFT 1 to 0 goes to CLEARING the same edge.
  - STOP or HALT_REQ aborts to CLEARING; STEPS_LEFT holds its value.
- CLEARING:
  - Drives RUN_R_N low for PULSE_W cycles.
  - Waits until RUN_Q=0, then pulses DONE for one cycle and returns to IDLE.
- Priority within one cycle: HALT_REQ > STOP > STEP > START.
- START/STEP outside IDLE are ignored. STOP during SETTING is held pending and acted on at SETTING exit.
- UINST_ADV outside STEPPING is ignored; STEPS_LEFT never wraps below 0.
- Reset mid-pulse releases both pulse outputs to 1 immediately (async).

Optional Feature:
- Macro: RUN_HALT_CAUSE_EN.
- Defined:
  - Adds output HALT_CAUSE[1:0], reset 0, loaded on entry to CLEARING: 1=STOP, 2=step count exhausted, 3=HALT_REQ.
  - Value holds until the next SETTING entry, which clears it to 0.
- Undefined: no port, no register.

Decomposition:
- Shared package run_ctl_pkg holds:
  - state encoding localparams;
  - halt-cause codes;
  - default CNT_W and PULSE_W.
- One sub-module, run_pulse_gen: PULSE_W-cycle low-pulse generator, instantiated twice (set and clear).

Test Plan:
- START with RUN_Q model -> RUN_S_N low for 2 cycles, BUSY=1. Then STOP -> RUN_R_N low for 2 cycles, DONE one cycle after RUN_Q=0, BUSY=0.
- STEP with STEP_COUNT=3, then 3 UINST_ADV pulses -> STEPS_LEFT goes 3,2,1,0; CLEARING entered on third; DONE once; HALT_CAUSE=2.
- STEP with count 5, HALT_REQ raised after 2 advances -> CLEARING; STEPS_LEFT=3; HALT_CAUSE=3.
- START and STOP in the same cycle in IDLE -> STOP wins; DONE only; RUN_S_N never low.
- RESET asserted mid-SETTING pulse -> RUN_S_N=1 immediately and state IDLE. After release, a STEP with count 0 produces DONE only.
- Check every cycle that RUN_S_N and RUN_R_N are never both low, using an assertion.
